// File: rtl/pixel_stream_tx.sv
// Frame-buffered pixel transmitter: preload a pixel buffer, then stream frame_len pixels gap-free.
// Optional `TX_SUM_EN adds per-channel running sums of the transmitted pixels.
module pixel_stream_tx #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int PIX_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              start,
  output logic              busy,
  output logic              pixel_valid,
  output logic [PIX_W-1:0]  pixel_output,
  output logic              frame_done,
  output logic              err
`ifdef TX_SUM_EN
  ,
  output logic [31:0]       tx_sum_r,
  output logic [31:0]       tx_sum_g,
  output logic [31:0]       tx_sum_b
`endif
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_t;

  state_t            state, state_nx;
  logic [PIX_W-1:0]  mem [DEPTH];
  logic [PIX_W-1:0]  rd_data;
  logic [ADDR_W-1:0] rd_addr, idx;
  logic [ADDR_W:0]   len_q;
  logic              len_ok, accept, last, err_nx;

  assign len_ok = (frame_len != '0) && (frame_len <= (ADDR_W+1)'(DEPTH));
  assign accept = (state == IDLE) && start && len_ok;
  assign last   = ({1'b0, idx} == len_q - 1'b1);

  always_comb begin
    state_nx = state;
    err_nx   = ((state == IDLE) && start && !len_ok) || (wr_en && (state != IDLE));
    case (state)
      IDLE:    if (accept) state_nx = PRIME;
      PRIME:   state_nx = STREAM;
      STREAM:  if (last) state_nx = FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Writes only land in IDLE, so the buffer never changes under an active read.
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE)) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_output <= '0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
      len_q        <= '0;
      rd_addr      <= '0;
      idx          <= '0;
    end else begin
      state       <= state_nx;
      err         <= err_nx;
      pixel_valid <= (state == STREAM);
      frame_done  <= (state == FLUSH);
      case (state)
        IDLE: if (accept) begin
          len_q   <= frame_len;
          rd_addr <= '0;
          idx     <= '0;
          busy    <= 1'b1;
        end
        PRIME: rd_addr <= rd_addr + 1'b1;
        STREAM: begin
          pixel_output <= rd_data;
          rd_addr      <= rd_addr + 1'b1;
          // idx stops at len-1 so a full-depth frame never wraps the counter
          if (!last) idx <= idx + 1'b1;
        end
        FLUSH: busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef TX_SUM_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      tx_sum_r <= '0;
      tx_sum_g <= '0;
      tx_sum_b <= '0;
    end else if (state == STREAM) begin
      tx_sum_r <= tx_sum_r + 32'(rd_data[23:16]);
      tx_sum_g <= tx_sum_g + 32'(rd_data[15:8]);
      tx_sum_b <= tx_sum_b + 32'(rd_data[7:0]);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Scoreboard bench for pixel_stream_tx: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_pixel_stream_tx;
  localparam int DEPTH = 256, ADDR_W = 8, PIX_W = 24;

  logic              clk = 0, reset = 1;
  logic              wr_en = 0, start = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic [ADDR_W:0]   frame_len = '0;
  logic              busy, pixel_valid, frame_done, err;
  logic [PIX_W-1:0]  pixel_output;
`ifdef TX_SUM_EN
  logic [31:0]       tx_sum_r, tx_sum_g, tx_sum_b;
`endif

  int errors = 0, checks = 0;
  logic [PIX_W-1:0] exp_q [$];
  logic [PIX_W-1:0] model [DEPTH];

  pixel_stream_tx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_len(frame_len), .start(start), .busy(busy), .pixel_valid(pixel_valid),
    .pixel_output(pixel_output), .frame_done(frame_done), .err(err)
`ifdef TX_SUM_EN
    , .tx_sum_r(tx_sum_r), .tx_sum_g(tx_sum_g), .tx_sum_b(tx_sum_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // monitor: every valid pixel must match the head of the scoreboard
  always @(negedge clk) begin
    if (pixel_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got=%h expected=none", pixel_output);
      end else begin
        logic [PIX_W-1:0] e;
        e = exp_q.pop_front();
        if (pixel_output !== e) begin
          errors++;
          $display("FAIL pixel_data: got=%h expected=%h", pixel_output, e);
        end
      end
    end
  end

  task automatic wr(input int a, input logic [PIX_W-1:0] d);
    wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d; model[a] = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic run_frame(input int len, input int wr_at, input bit co_wr, input logic [PIX_W-1:0] co_data);
    int n, vbad;
    bit done_seen;
    logic [31:0] sr, sg, sb;
    if (co_wr) begin
      wr_en = 1; wr_addr = '0; wr_data = co_data; model[0] = co_data;
    end
    sr = 0; sg = 0; sb = 0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model[i]);
      sr += 32'(model[i][23:16]); sg += 32'(model[i][15:8]); sb += 32'(model[i][7:0]);
    end
    frame_len = (ADDR_W+1)'(len); start = 1;
    @(posedge clk); #1;
    start = 0; wr_en = 0;
    chk("busy_on", 32'(busy), 1);
    n = 0; vbad = 0; done_seen = 0;
    while (!done_seen && n < len + 10) begin
      @(posedge clk); #1;
      n++;
      if (wr_at != 0 && n == wr_at) begin
        wr_en = 1; wr_addr = 8'd2; wr_data = 24'hDEAD00;
      end else wr_en = 0;
      if (wr_at != 0 && n == wr_at + 1) chk("err_wr_busy", 32'(err), 1);
      if (pixel_valid !== (n >= 2 && n <= len + 1)) vbad++;
      if (frame_done) done_seen = 1;
    end
    wr_en = 0;
    chk("done_latency", 32'(n), 32'(len + 2));
    chk("valid_window", 32'(vbad), 0);
    chk("busy_off", 32'(busy), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
`ifdef TX_SUM_EN
    chk("sum_r", tx_sum_r, sr);
    chk("sum_g", tx_sum_g, sg);
    chk("sum_b", tx_sum_b, sb);
`endif
    @(posedge clk); #1;
    chk("done_pulse", 32'(frame_done), 0);
  endtask

  task automatic bad_start(input int len);
    frame_len = (ADDR_W+1)'(len); start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("err_badlen", 32'(err), 1);
    chk("busy_badlen", 32'(busy), 0);
    @(posedge clk); #1;
    chk("err_pulse", 32'(err), 0);
  endtask

  initial begin
    int n, dones;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_pix", 32'(pixel_output), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(err), 0);
    reset = 0;
    @(posedge clk); #1;

    // basic 4-pixel frame
    wr(0, 24'h102030); wr(1, 24'h203040); wr(2, 24'h304050); wr(3, 24'h405060);
    run_frame(4, 0, 0, '0);
`ifdef TX_SUM_EN
    chk("sum_r_spec", tx_sum_r, 32'hA0);
    chk("sum_g_spec", tx_sum_g, 32'hE0);
    chk("sum_b_spec", tx_sum_b, 32'h120);
`endif

    // single pixel
    wr(0, 24'hFFFFFF);
    run_frame(1, 0, 0, '0);

    // write and start on the same edge: frame must carry the new data
    run_frame(1, 0, 1, 24'h123456);

    // illegal lengths
    bad_start(0);
    bad_start(DEPTH + 1);

    // write during stream is dropped and flagged
    wr(0, 24'h102030); wr(1, 24'h203040); wr(2, 24'h304050); wr(3, 24'h405060);
    run_frame(4, 3, 0, '0);
    run_frame(4, 0, 0, '0);

    // full-depth frame
    for (int i = 0; i < DEPTH; i++) wr(i, {3{8'(i)}});
    run_frame(DEPTH, 0, 0, '0);

    // reset in the middle of a frame
    wr(0, 24'hA1A2A3); wr(1, 24'hB1B2B3); wr(2, 24'hC1C2C3); wr(3, 24'hD1D2D3);
    for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
    frame_len = 9'd4; start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_rst_valid", 32'(pixel_valid), 1);
    reset = 1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(pixel_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(frame_done), 0);
    @(negedge clk);
    exp_q.delete();
    #1;
    reset = 0;
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (frame_done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 0);
    run_frame(4, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
